// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce/synchroniser block.
// The long-press option is enabled with DEBOUNCE_LONG_PRESS_EN.
package debounce_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 4;
  localparam int STABLE_CYCLES_DEF = 50000;
  localparam int LONG_CYCLES_DEF   = 1000000;
  localparam int LONG_CNT_W        = 24;

endpackage

// File: rtl/debounce_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level.
// Reused by other CDC inputs; q is the only output stage to consume.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES out of range");
  end

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= {SYNC_STAGES{RESET_VAL}};
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], d};
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise, debounce and edge-detect a raw asynchronous level.
// Optional long-press detector enabled with DEBOUNCE_LONG_PRESS_EN.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int   CNT_W         = 16,
  parameter logic RESET_VAL     = 1'b0
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  parameter int   LONG_CYCLES   = LONG_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_stable
    $error("debounce_sync: STABLE_CYCLES does not fit CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

  logic             w_s;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (w_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dout  <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Any sample matching dout during CHECK abandons the candidate level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_s != r_dout) begin
          w_state_nxt = CHECK;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      CHECK: begin
        if (w_s == r_dout) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_TERM) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_dout_nxt  = w_s;
          w_rise_nxt  = w_s;
          w_fall_nxt  = ~w_s;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = (r_state == CHECK);

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [LONG_CNT_W-1:0] LONG_SAT  = LONG_CNT_W'(LONG_CYCLES);
  localparam logic [LONG_CNT_W-1:0] LONG_TERM = LONG_CNT_W'(LONG_CYCLES - 1);

  logic [LONG_CNT_W-1:0] r_long_cnt;
  logic                  r_long_press;

  // Saturating at LONG_SAT stops repeats until dout drops and rises again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_long_cnt   <= '0;
      r_long_press <= 1'b0;
    end else begin
      r_long_press <= 1'b0;
      if (!r_dout) begin
        r_long_cnt <= '0;
      end else if (r_long_cnt != LONG_SAT) begin
        r_long_cnt   <= r_long_cnt + LONG_CNT_W'(1);
        r_long_press <= (r_long_cnt == LONG_TERM);
      end
    end
  end

  assign long_press = r_long_press;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync (SYNC_STAGES=2, STABLE_CYCLES=4).
// Define DEBOUNCE_LONG_PRESS_EN to also exercise long_press with LONG_CYCLES=8.
module tb_debounce_sync;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int LONG   = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b0;
  logic dout, rise, fall, busy;
`ifdef DEBOUNCE_LONG_PRESS_EN
  logic long_press;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  debounce_sync #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .CNT_W         (16),
    .RESET_VAL     (1'b0)
`ifdef DEBOUNCE_LONG_PRESS_EN
    ,
    .LONG_CYCLES   (LONG)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
`ifdef DEBOUNCE_LONG_PRESS_EN
    ,
    .long_press (long_press)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: din delayed through SYNC samples; dout follows once the
  // last STABLE samples since the previous change all disagree with it.
  bit pipe[SYNC];
  bit hist[$];
  bit m_dout, m_rise, m_fall, m_busy, m_long;
  int hi_age;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
    hist.delete();
    m_dout = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_long = 0;
    hi_age = 0;
  endtask

  task automatic model_edge(input bit d);
    bit s_seen;
    bit all_diff;
    s_seen = pipe[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = d;
    m_rise = 0; m_fall = 0; m_long = 0;
    if (m_dout) begin
      hi_age++;
      m_long = (hi_age == LONG);
    end
    hist.push_back(s_seen);
    if (hist.size() > STABLE) void'(hist.pop_front());
    all_diff = (hist.size() == STABLE);
    foreach (hist[i]) if (hist[i] == m_dout) all_diff = 0;
    if (all_diff) begin
      m_dout = s_seen;
      m_rise = s_seen;
      m_fall = ~s_seen;
      hist.delete();
      hi_age = 0;
    end
    m_busy = (s_seen != m_dout);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic d);
    din = d;
    @(posedge clk);
    if (reset) model_edge(d);
    else       model_reset();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_dout"}, dout, m_dout);
    chk({tag, "_rise"}, rise, m_rise);
    chk({tag, "_fall"}, fall, m_fall);
    chk({tag, "_busy"}, busy, m_busy);
    chk({tag, "_excl"}, rise & fall, 1'b0);
`ifdef DEBOUNCE_LONG_PRESS_EN
    chk({tag, "_long"}, long_press, m_long);
`endif
  endtask

  task automatic glitch(input int len, input string tag);
    bit saw_busy = 0, saw_rise = 0, saw_dout = 0;
    for (int i = 0; i < len + 8; i++) begin
      step(i < len);
      saw_busy |= busy;
      saw_rise |= rise;
      saw_dout |= dout;
    end
    chk({tag, "_busy_seen"}, saw_busy, 1'b1);
    chk({tag, "_no_rise"}, saw_rise, 1'b0);
    chk({tag, "_dout_low"}, saw_dout, 1'b0);
  endtask

  typedef struct {
    logic d;
    logic dout;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // clean rise, then clean fall
    tbl[0]  = '{1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1};
    tbl[3]  = '{1, 0, 0, 0, 1};
    tbl[4]  = '{1, 0, 0, 0, 1};
    tbl[5]  = '{1, 1, 1, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 1};
    tbl[12] = '{0, 1, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0};

    model_reset();

    // Reset held with din high
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk("rst_dout", dout, 1'b0);
      chk("rst_rise", rise, 1'b0);
      chk("rst_fall", fall, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      chk("idle_dout", dout, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_pulse", rise | fall, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].d);
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
      chk($sformatf("tbl%0d_rise", i), rise, tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), fall, tbl[i].fall);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
    end

    glitch(3, "glitch3");
    glitch(1, "glitch1");

    // Bounce then settle high
    begin
      int n_rise = 0, n_fall = 0, rise_at = -1;
      for (int i = 0; i < 10; i++) begin
        step((i % 2) == 0);
        n_rise += int'(rise);
        n_fall += int'(fall);
      end
      for (int k = 1; k <= 10; k++) begin
        step(1'b1);
        if (rise) rise_at = k;
        n_rise += int'(rise);
        n_fall += int'(fall);
      end
      chk("bounce_one_rise", n_rise == 1, 1'b1);
      chk("bounce_no_fall", n_fall == 0, 1'b1);
      chk("bounce_rise_at6", rise_at == 6, 1'b1);
      chk("bounce_dout", dout, 1'b1);
    end

    // Reset mid-qualification, asserted between edges
    reset = 1'b0;
    step(1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("midq_busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("midq_busy_async", busy, 1'b0);
    chk("midq_dout_async", dout, 1'b0);
    step(1'b1);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1'b1);
      chk($sformatf("midq_dout_e%0d", k), dout, k == 6);
      chk($sformatf("midq_rise_e%0d", k), rise, k == 6);
    end
`ifdef DEBOUNCE_LONG_PRESS_EN
    for (int k = 1; k <= 12; k++) begin
      step(1'b1);
      chk($sformatf("long_e%0d", k), long_press, k == LONG);
    end
`endif

    // Randomised runs against the model, with occasional async resets
    begin
      bit lvl = 0;
      int cyc = 0;
      while (cyc < 3000) begin
        int run = $urandom_range(1, 7);
        if ($urandom_range(0, 3) == 0) run = $urandom_range(4, 14);
        lvl = ~lvl;
        for (int i = 0; i < run; i++) begin
          if ($urandom_range(0, 299) == 0) begin
            reset = 1'b0;
            model_reset();
            #1;
            check_model("rnd_rst");
            step(lvl);
            reset = 1'b1;
          end else begin
            step(lvl);
          end
          check_model("rnd");
          cyc++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
